// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU port, display port and memory-side signals of mem_arbiter.
// master: the requesters plus the memory (drives requests and mem_rdata).
// slave:  the arbiter itself.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              lock0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    output req0, we0, addr0, wdata0, lock0, req1, addr1, mem_rdata,
    input  ack0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0, lock0, req1, addr1, mem_rdata,
    output ack0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Port 0 = CPU (read/write, optional lock), port 1 = display refresh (read only).
// One transaction at a time: IDLE (arbitrate) -> ISSUE (mem_en) -> WAIT (ack).
// Read data from the memory arrives in the WAIT cycle and is forwarded straight
// to the acked port, so rdataN is valid exactly while ackN is high.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, next_state;
  logic              last;
  logic              locked;
  logic              cmd_port;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              grant;
  logic              grant_port;

  // Next state and arbitration winner; lock beats round-robin for the CPU
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    unique case (state)
      IDLE: begin
        if (locked && bus.req0) begin
          grant      = 1'b1;
          grant_port = 1'b0;
        end else if (bus.req0 && bus.req1) begin
          grant      = 1'b1;
          grant_port = ~last;
        end else if (bus.req0) begin
          grant      = 1'b1;
          grant_port = 1'b0;
        end else if (bus.req1) begin
          grant      = 1'b1;
          grant_port = 1'b1;
        end
        if (grant) next_state = ISSUE;
      end
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Command latch, round-robin pointer and CPU lock bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= 1'b1;
      locked    <= 1'b0;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      if (state == IDLE) begin
        // A lock held while the CPU is not asking would only starve the display
        if (!bus.req0) locked <= 1'b0;
        if (grant) begin
          cmd_port  <= grant_port;
          cmd_we    <= grant_port ? 1'b0 : bus.we0;
          cmd_addr  <= grant_port ? bus.addr1 : bus.addr0;
          cmd_wdata <= grant_port ? '0 : bus.wdata0;
          last      <= grant_port;
        end
      end
      if (state == WAIT) locked <= cmd_port ? 1'b0 : bus.lock0;
    end
  end

  // Memory strobes and per-port completion, decoded from the current state
  always_comb begin
    bus.mem_en    = (state == ISSUE);
    bus.mem_we    = (state == ISSUE) && cmd_we;
    bus.mem_addr  = cmd_addr;
    bus.mem_wdata = cmd_wdata;
    bus.ack0      = (state == WAIT) && !cmd_port;
    bus.ack1      = (state == WAIT) && cmd_port;
    bus.rdata0    = ((state == WAIT) && !cmd_port) ? bus.mem_rdata : '0;
    bus.rdata1    = ((state == WAIT) && cmd_port) ? bus.mem_rdata : '0;
    bus.busy      = (state != IDLE);
  end

endmodule
